// File: rtl/pipelined_adder.sv
//-----------------------------------------------------------------------------
// PipelinedAdder (module pipelined_adder)
//
// Purpose:
//   WIDTH-bit adder split into STAGES = WIDTH/SLICE registered slices. Each
//   stage adds one SLICE-wide chunk of the operands plus the carry registered
//   by the previous stage. Operand bits that have not been added yet travel
//   forward with the beat, and finished sum bits are carried along too. As a
//   result, all slices of one beat leave the last stage together.
//   Flow control is a valid/ready handshake with a single global advance
//   enable. When the output holds a beat that is not consumed, the whole
//   pipeline freezes. Bubbles are kept and never collapsed.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 4)
//   SLICE  bits added per stage (WIDTH must be a multiple of SLICE)
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   beat accepted when in_valid && in_ready (equals advance enable)
//   a, b       operands
//   c_in       carry-in, sampled with a/b
//   out_valid  result beat present
//   out_ready  result consumed when out_valid && out_ready
//   s          low WIDTH bits of a+b+c_in
//   c_out      carry out of bit WIDTH-1
//   ovf        signed overflow, aligned with s (only with the macro below)
//
// Configuration:
//   Define PIPELINED_ADDER_OVF_EN to add the ovf output and its logic.
//-----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int MSB    = WIDTH - 1;

    generate
        if (WIDTH < 4 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_badParams
            $error("pipelined_adder: WIDTH must be >= 4 and a multiple of SLICE");
        end
    endgenerate

    // Global advance enable shared by every stage.
    logic w_advance;

    // Per-stage inputs. Stage 0 takes them from the ports, and stage k takes
    // them from the registers of stage k-1.
    logic [WIDTH-1:0] w_aIn     [STAGES];
    logic [WIDTH-1:0] w_bIn     [STAGES];
    logic [WIDTH-1:0] w_sumIn   [STAGES];
    logic             w_carryIn [STAGES];
    logic             w_validIn [STAGES];

    // Per-stage slice result and the merged partial sum.
    logic [SLICE:0]   w_sliceSum [STAGES];
    logic [WIDTH-1:0] w_sumOut   [STAGES];

    // Stage registers. The operand copies hold the not-yet-added upper slices.
    // Lower bits that are already consumed are dead and get trimmed by synthesis.
    logic [WIDTH-1:0] r_aPipe   [STAGES];
    logic [WIDTH-1:0] r_bPipe   [STAGES];
    logic [WIDTH-1:0] r_sumPipe [STAGES];
    logic             r_carry   [STAGES];
    logic             r_valid   [STAGES];

    // The pipeline moves when the last stage is empty or is being drained.
    // This does not depend on in_valid.
    always_comb begin
        w_advance = !r_valid[STAGES-1] || out_ready;
        in_ready  = w_advance;
    end

    always_comb begin
        w_aIn[0]     = a;
        w_bIn[0]     = b;
        w_sumIn[0]   = '0;
        w_carryIn[0] = c_in;
        w_validIn[0] = in_valid && w_advance;
        for (int k = 1; k < STAGES; k++) begin
            w_aIn[k]     = r_aPipe[k-1];
            w_bIn[k]     = r_bPipe[k-1];
            w_sumIn[k]   = r_sumPipe[k-1];
            w_carryIn[k] = r_carry[k-1];
            w_validIn[k] = r_valid[k-1];
        end
    end

    // Each stage adds its own slice with a one-bit-wider result so that the
    // slice carry lands in the top bit. That sum is then merged into the
    // partial sum word that travels with the beat.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sliceSum[k] = {1'b0, w_aIn[k][k*SLICE +: SLICE]}
                          + {1'b0, w_bIn[k][k*SLICE +: SLICE]}
                          + {{SLICE{1'b0}}, w_carryIn[k]};
            w_sumOut[k]   = w_sumIn[k];
            w_sumOut[k][k*SLICE +: SLICE] = w_sliceSum[k][SLICE-1:0];
        end
    end

    // When the pipeline is stalled, every stage keeps its value. Bubbles move
    // forward just like valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k]   <= 1'b0;
                r_carry[k]   <= 1'b0;
                r_aPipe[k]   <= '0;
                r_bPipe[k]   <= '0;
                r_sumPipe[k] <= '0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k]   <= w_validIn[k];
                r_carry[k]   <= w_sliceSum[k][SLICE];
                r_aPipe[k]   <= w_aIn[k];
                r_bPipe[k]   <= w_bIn[k];
                r_sumPipe[k] <= w_sumOut[k];
            end
        end
    end

    always_comb begin
        out_valid = r_valid[STAGES-1];
        s         = r_sumPipe[STAGES-1];
        c_out     = r_carry[STAGES-1];
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // The operand MSBs live in the last slice. Overflow is computed there, so
    // it is registered in step with s.
    logic w_ovfNext;
    logic r_ovf;

    always_comb begin
        w_ovfNext = (w_aIn[STAGES-1][MSB] == w_bIn[STAGES-1][MSB])
                 && (w_sumOut[STAGES-1][MSB] != w_aIn[STAGES-1][MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_ovfNext;
        end
    end

    always_comb begin
        ovf = r_ovf;
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
//-----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Purpose:
//   Self-checking bench for pipelined_adder (WIDTH=16, SLICE=4).
//   The reference is a STAGES-deep line of finished results, each computed
//   directly as a+b+c_in. The line shifts whenever the output is empty or
//   consumed. Directed scenarios cover single sums, carry ripple, signed
//   overflow (when PIPELINED_ADDER_OVF_EN is defined), back-to-back beats,
//   a long stall and a reset in mid flight. A randomized handshake phase
//   follows.
//-----------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int STAGES = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    pipelined_adder #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
`ifdef PIPELINED_ADDER_OVF_EN
        .c_out    (c_out),
        .ovf      (ovf)
`else
        .c_out    (c_out)
`endif
    );

    always #5 clk = ~clk;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference: one slot per pipeline stage, holding the finished result.
    logic             modelValid [STAGES];
    logic [WIDTH:0]   modelSum   [STAGES];
    logic             modelOvf   [STAGES];

    int acceptedBeats  = 0;
    int deliveredBeats = 0;

    logic             lastOutValid;
    logic [WIDTH-1:0] lastS;
    logic             lastCout;
    logic             lastOvf;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb, input logic cc,
                                 input logic rdy);
        in_valid  = v;
        a         = aa;
        b         = bb;
        c_in      = cc;
        out_ready = rdy;
    endtask

    task automatic clearModel();
        for (int k = 0; k < STAGES; k++) begin
            modelValid[k] = 1'b0;
            modelSum[k]   = '0;
            modelOvf[k]   = 1'b0;
        end
    endtask

    // Compare the DUT outputs with the reference. Call this mid-cycle.
    task automatic compareModel();
        logic expAdvance;
        expAdvance   = !modelValid[STAGES-1] || out_ready;
        lastOutValid = out_valid;
        lastS        = s;
        lastCout     = c_out;
`ifdef PIPELINED_ADDER_OVF_EN
        lastOvf      = ovf;
`else
        lastOvf      = 1'b0;
`endif
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expAdvance});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, modelValid[STAGES-1]});
        if (modelValid[STAGES-1]) begin
            checkOutput("s", {16'd0, s}, {16'd0, modelSum[STAGES-1][WIDTH-1:0]});
            checkOutput("c_out", {31'd0, c_out}, {31'd0, modelSum[STAGES-1][WIDTH]});
`ifdef PIPELINED_ADDER_OVF_EN
            checkOutput("ovf", {31'd0, ovf}, {31'd0, modelOvf[STAGES-1]});
`endif
        end
        if (out_valid && out_ready) deliveredBeats++;
    endtask

    // Update the reference at the rising edge, using the inputs that were held
    // through the cycle.
    task automatic advanceModel();
        logic [WIDTH:0] sum;
        if (!modelValid[STAGES-1] || out_ready) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                modelValid[k] = modelValid[k-1];
                modelSum[k]   = modelSum[k-1];
                modelOvf[k]   = modelOvf[k-1];
            end
            sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
            modelValid[0] = in_valid;
            modelSum[0]   = sum;
            modelOvf[0]   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            if (in_valid) acceptedBeats++;
        end
    endtask

    task automatic doCycle(input logic v, input logic [WIDTH-1:0] aa,
                           input logic [WIDTH-1:0] bb, input logic cc,
                           input logic rdy);
        applyStimulus(v, aa, bb, cc, rdy);
        @(negedge clk);
        compareModel();
        @(posedge clk);
        advanceModel();
        #1;
    endtask

    // Send one beat into an empty pipeline. Then wait, with a bound, for the
    // result to show up and return how many cycles that took.
    task automatic runSingle(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                             input logic cc, output int latency);
        latency = -1;
        doCycle(1'b1, aa, bb, cc, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            doCycle(1'b0, '0, '0, 1'b0, 1'b1);
            if (lastOutValid && latency < 0) latency = i;
        end
    endtask

    int               lat;
    logic [WIDTH-1:0] hitS;
    logic             hitC;
    logic             hitO;

    // Like runSingle, but also keeps the outputs seen in the result cycle.
    task automatic runSingleCapture(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                    input logic cc);
        lat  = -1;
        hitS = '0;
        hitC = 1'b0;
        hitO = 1'b0;
        doCycle(1'b1, aa, bb, cc, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            doCycle(1'b0, '0, '0, 1'b0, 1'b1);
            if (lastOutValid && lat < 0) begin
                lat  = i;
                hitS = lastS;
                hitC = lastCout;
                hitO = lastOvf;
            end
        end
    endtask

    initial begin
        clearModel();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_s", {16'd0, s}, 32'd0);
        checkOutput("reset_c_out", {31'd0, c_out}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Smallest sum. Also measures latency.
        runSingleCapture(16'h0000, 16'h0001, 1'b0);
        checkOutput("lat_0p1", lat, STAGES);
        checkOutput("s_0p1", {16'd0, hitS}, 32'h0001);
        checkOutput("c_0p1", {31'd0, hitC}, 32'd0);

        // The carry ripples through every stage.
        runSingleCapture(16'hFFFF, 16'h0001, 1'b0);
        checkOutput("lat_ffff", lat, STAGES);
        checkOutput("s_ffff", {16'd0, hitS}, 32'h0000);
        checkOutput("c_ffff", {31'd0, hitC}, 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        checkOutput("ovf_ffff", {31'd0, hitO}, 32'd0);
`endif

        // Signed overflow boundary.
        runSingleCapture(16'h7FFF, 16'h0001, 1'b0);
        checkOutput("s_7fff", {16'd0, hitS}, 32'h8000);
        checkOutput("c_7fff", {31'd0, hitC}, 32'd0);
`ifdef PIPELINED_ADDER_OVF_EN
        checkOutput("ovf_7fff", {31'd0, hitO}, 32'd1);
`endif

        // Carry-in only.
        runSingle(16'hFFFF, 16'h0000, 1'b1, lat);
        checkOutput("lat_cin", lat, STAGES);

        // Eight back-to-back beats, then drain.
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] iv;
            iv = WIDTH'(i);
            doCycle(1'b1, iv, 16'h0F0F, iv[0], 1'b1);
        end
        for (int i = 0; i < STAGES + 2; i++) doCycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Fill the pipeline, then stall the output for six cycles while
        // offering new beats.
        for (int i = 0; i < STAGES; i++)
            doCycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 6; i++)
            doCycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < STAGES + 3; i++) doCycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Reset while three beats are in flight.
        for (int i = 0; i < 3; i++)
            doCycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_s", {16'd0, s}, 32'd0);
        checkOutput("midrst_c_out", {31'd0, c_out}, 32'd0);
        clearModel();
        acceptedBeats  = 0;
        deliveredBeats = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // With out_ready low, in_ready can only be 1 if the pipeline is empty.
        doCycle(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < STAGES + 3; i++) doCycle(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("midrst_no_stale", deliveredBeats, 0);

        // Randomized handshakes on both sides.
        for (int i = 0; i < 400; i++)
            doCycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    1'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < STAGES + 3; i++) doCycle(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("beat_count", deliveredBeats, acceptedBeats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (>=4).
REQ-002 SHALL have parameter SLICE, default 4, bits added per pipeline stage; WIDTH mod SLICE == 0; STAGES = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  WIDTH  unsigned/two's-complement operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port c_in  input  1  carry-in, sampled with a/b.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port s  output  WIDTH  sum, low WIDTH bits of a+b+c_in.
REQ-013 SHALL have port c_out  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL split addition into STAGES registered stages; stage k adds bits [k*SLICE +: SLICE] of a, b with carry registered from stage k-1 (stage 0 uses c_in).
REQ-015 SHALL skew unused upper operand slices forward and delay completed lower sum slices so all slices of one beat emerge together.
REQ-016 SHALL hold a valid bit per stage; result {c_out,s} SHALL equal a+b+c_in computed to WIDTH+1 bits exactly.
REQ-017 SHALL use a global advance enable adv = !out_valid || out_ready; every stage register and valid bit updates only when adv is 1.
REQ-018 SHALL drive in_ready = adv combinationally; in_ready SHALL NOT depend on in_valid.
REQ-019 SHALL load stage-0 valid with (in_valid && in_ready) on advance; bubbles propagate and are not collapsed.
REQ-020 SHALL give latency exactly STAGES cycles from acceptance edge to out_valid high, with no stall; throughput one beat per cycle.
REQ-021 SHALL hold s, c_out, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, when out_valid && out_ready && new beat arriving at last stage in same cycle, present the new beat next cycle (no lost or duplicated beat).
REQ-023 SHALL wrap modulo 2^WIDTH in s; full carry reported solely on c_out.
REQ-024 SHALL preserve beat order; no reordering or drop under any in_valid/out_ready pattern.

Reset
REQ-025 SHALL on rst_n low, asynchronously clear all valid bits, out_valid=0, s=0, c_out=0, internal carries=0.
REQ-026 SHALL discard all in-flight beats on reset mid-operation; in_ready=1 the first cycle after release.
REQ-027 SHALL deassert reset synchronously w.r.t. clk by the integrator; block assumes no reset-release metastability handling.

Configuration
REQ-028 SHALL, with macro PIPELINED_ADDER_OVF_EN defined, add port ovf  output  1, signed overflow = (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]), aligned with s, reset 0.
REQ-029 SHALL, without PIPELINED_ADDER_OVF_EN, omit ovf port and its logic entirely.

Verification (WIDTH=16, SLICE=4)
REQ-030 SHALL cover: a=0x0000,b=0x0001,c_in=0, out_ready=1 -> out_valid 4 cycles later, s=0x0001, c_out=0.
REQ-031 SHALL cover: a=0xFFFF,b=0x0001,c_in=0 -> s=0x0000, c_out=1 (carry ripples through all 4 stages); ovf=0 if enabled.
REQ-032 SHALL cover: a=0x7FFF,b=0x0001 with PIPELINED_ADDER_OVF_EN -> s=0x8000, c_out=0, ovf=1.
REQ-033 SHALL cover: back-to-back 8 beats a=i,b=0x0F0F,c_in=i[0], out_ready=1 -> 8 consecutive results, in order, each a+b+c_in.
REQ-034 SHALL cover: out_ready=0 for 6 cycles with pipeline full -> in_ready=0, s/out_valid held; release -> remaining beats delivered, none lost/duplicated.
REQ-035 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0, s=0 immediately; no stale beat emerges after release.
